// File: rtl/ipl_sync_filter.sv
`default_nettype none
// ============================================================================
// Module      : ipl_sync_filter
// Description : Synchronises and de-glitches the 68K IPL lines, freezes
//               reported level changes during Pi bus transactions and
//               latches a level-7 (NMI) entry until the Pi reads status.
// Revision    : 1.0 - initial release
// ============================================================================
module ipl_sync_filter #(
    parameter int STABLE_CYCLES = 2,
    parameter int FREEZE_ON_TXN = 1
) (
    input  logic       clk,
    input  logic       s0rst,
    input  logic       sample_en,
    input  logic [2:0] ipl_n,
    input  logic       txn_busy,
    input  logic       status_rd,
    output logic [2:0] ipl_out,
    output logic       pi_ipl1,
    output logic       pi_ipl2,
    output logic       irq_pending,
    output logic       nmi_latched,
    output logic       ipl_changed
);

    localparam logic [2:0] c_stable_cnt = 3'(STABLE_CYCLES);
    localparam logic [2:0] c_nmi_level  = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        LATCH7 = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_cand;
    logic [2:0] r_cnt;
    logic [2:0] r_stable;
    logic [2:0] r_prev_stable;
    logic [2:0] r_ipl_out;
    logic       r_changed;
    logic [2:0] w_cand_nxt;
    logic [2:0] w_cnt_nxt;
    logic [2:0] w_ipl_nxt;
    logic       w_freeze;

    assign w_freeze = (FREEZE_ON_TXN != 0) && txn_busy;

    // Two-flop synchroniser on the inverted (active-high) IPL lines.
    always_ff @(posedge clk or posedge s0rst) begin
        if (s0rst) begin
            r_sync1 <= 3'd0;
            r_sync2 <= 3'd0;
        end else begin
            r_sync1 <= ~ipl_n;
            r_sync2 <= r_sync1;
        end
    end

    // Next candidate/run-length: restart the run on any level change, else extend it (saturating).
    always_comb begin
        w_cand_nxt = r_cand;
        w_cnt_nxt  = r_cnt;
        if (r_sync2 == r_cand) begin
            if (r_cnt != c_stable_cnt) begin
                w_cnt_nxt = r_cnt + 3'd1;
            end
        end else begin
            w_cand_nxt = r_sync2;
            w_cnt_nxt  = 3'd1;
        end
    end

    // Glitch filter advancing on sample strobes; a run of STABLE_CYCLES equal samples is accepted.
    always_ff @(posedge clk or posedge s0rst) begin
        if (s0rst) begin
            r_cand   <= 3'd0;
            r_cnt    <= 3'd0;
            r_stable <= 3'd0;
        end else if (sample_en) begin
            r_cand <= w_cand_nxt;
            r_cnt  <= w_cnt_nxt;
            if (w_cnt_nxt == c_stable_cnt) begin
                r_stable <= w_cand_nxt;
            end
        end
    end

    // Reporting state machine: next state and next reported level.
    always_comb begin
        w_state_nxt = r_state;
        w_ipl_nxt   = r_ipl_out;
        case (r_state)
            IDLE: begin
                if (r_stable == c_nmi_level) begin
                    w_state_nxt = LATCH7;
                    w_ipl_nxt   = c_nmi_level;
                end else if ((r_stable != 3'd0) && !w_freeze) begin
                    w_state_nxt = ACTIVE;
                    w_ipl_nxt   = r_stable;
                end
            end
            ACTIVE: begin
                // Only a fresh rise to 7 latches; a 7 held across an ack does not.
                if ((r_stable == c_nmi_level) && (r_prev_stable != c_nmi_level)) begin
                    w_state_nxt = LATCH7;
                    w_ipl_nxt   = c_nmi_level;
                end else if (!w_freeze && (r_stable != r_ipl_out)) begin
                    w_ipl_nxt = r_stable;
                    if (r_stable == 3'd0) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            LATCH7: begin
                if (status_rd) begin
                    w_ipl_nxt   = r_stable;
                    w_state_nxt = (r_stable == 3'd0) ? IDLE : ACTIVE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ipl_nxt   = 3'd0;
            end
        endcase
    end

    // State, reported level, previous stable level and change pulse registers.
    always_ff @(posedge clk or posedge s0rst) begin
        if (s0rst) begin
            r_state       <= IDLE;
            r_ipl_out     <= 3'd0;
            r_prev_stable <= 3'd0;
            r_changed     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ipl_out     <= w_ipl_nxt;
            r_prev_stable <= r_stable;
            r_changed     <= (w_ipl_nxt != r_ipl_out);
        end
    end

    assign ipl_out     = r_ipl_out;
    assign pi_ipl1     = r_ipl_out[1];
    assign pi_ipl2     = r_ipl_out[2];
    assign irq_pending = (r_ipl_out != 3'd0);
    assign nmi_latched = (r_state == LATCH7);
    assign ipl_changed = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_ipl_sync_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ipl_sync_filter
// Description : Self-checking bench for ipl_sync_filter with a behavioural
//               reference model (sample history + reported level/NMI flag).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ipl_sync_filter;

    localparam int N_STABLE = 2;
    localparam int FREEZE   = 1;

    logic       clk;
    logic       s0rst;
    logic       sample_en;
    logic [2:0] ipl_n;
    logic       txn_busy;
    logic       status_rd;
    logic [2:0] ipl_out;
    logic       pi_ipl1;
    logic       pi_ipl2;
    logic       irq_pending;
    logic       nmi_latched;
    logic       ipl_changed;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [2:0] m_s1, m_s2, m_stable, m_prev, m_out;
    logic       m_nmi, m_chg;
    int         hist[$];

    ipl_sync_filter #(
        .STABLE_CYCLES(N_STABLE),
        .FREEZE_ON_TXN(FREEZE)
    ) dut (
        .clk        (clk),
        .s0rst      (s0rst),
        .sample_en  (sample_en),
        .ipl_n      (ipl_n),
        .txn_busy   (txn_busy),
        .status_rd  (status_rd),
        .ipl_out    (ipl_out),
        .pi_ipl1    (pi_ipl1),
        .pi_ipl2    (pi_ipl2),
        .irq_pending(irq_pending),
        .nmi_latched(nmi_latched),
        .ipl_changed(ipl_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = 3'd0; m_s2 = 3'd0; m_stable = 3'd0; m_prev = 3'd0;
        m_out = 3'd0; m_nmi = 1'b0; m_chg = 1'b0;
        hist.delete();
    endtask

    function automatic bit last_n_equal();
        if (hist.size() < N_STABLE) return 1'b0;
        for (int k = hist.size() - N_STABLE; k < hist.size(); k++)
            if (hist[k] != hist[hist.size() - 1]) return 1'b0;
        return 1'b1;
    endfunction

    // Advance the model by one clock using the current inputs, then clock the DUT and compare.
    task automatic tick(input string tag);
        logic [2:0] n_stable, n_out;
        logic       n_nmi;
        if (s0rst) begin
            model_reset();
        end else begin
            n_stable = m_stable;
            n_out    = m_out;
            n_nmi    = m_nmi;
            if (sample_en) begin
                hist.push_back(int'(m_s2));
                if (hist.size() > 8) void'(hist.pop_front());
                if (last_n_equal()) n_stable = m_s2;
            end
            if (m_nmi) begin
                if (status_rd) begin
                    n_nmi = 1'b0;
                    n_out = m_stable;
                end
            end else if (m_stable == 3'd7 && (m_out == 3'd0 || m_prev != 3'd7)) begin
                n_nmi = 1'b1;
                n_out = 3'd7;
            end else if (!(FREEZE != 0 && txn_busy)) begin
                n_out = m_stable;
            end
            m_chg    = (n_out != m_out);
            m_prev   = m_stable;
            m_s2     = m_s1;
            m_s1     = ~ipl_n;
            m_stable = n_stable;
            m_out    = n_out;
            m_nmi    = n_nmi;
        end
        @(posedge clk);
        #1;
        chk(tag, {ipl_out, pi_ipl2, pi_ipl1, irq_pending, nmi_latched, ipl_changed},
                 {m_out, m_out[2], m_out[1], (m_out != 3'd0), m_nmi, m_chg});
    endtask

    // One strobe = two idle clocks followed by a qualified clock.
    task automatic strobes(input int n, input string tag);
        for (int s = 0; s < n; s++) begin
            sample_en = 1'b0; tick(tag);
            tick(tag);
            sample_en = 1'b1; tick(tag);
            sample_en = 1'b0;
        end
    endtask

    task automatic pulse_rd(input string tag);
        status_rd = 1'b1; tick(tag);
        status_rd = 1'b0;
    endtask

    initial begin
        s0rst = 1'b1; sample_en = 1'b0; ipl_n = 3'b111; txn_busy = 1'b0; status_rd = 1'b0;
        model_reset();
        #2;
        tick("reset");
        tick("reset");
        chk("reset_out", {5'd0, ipl_out}, 8'd0);
        s0rst = 1'b0;

        // Idle level for 20 strobes: nothing reported.
        strobes(20, "idle");
        chk("idle_irq", {7'd0, irq_pending}, 8'd0);

        // One-strobe glitch of level 4 is filtered.
        ipl_n = 3'b011; strobes(1, "glitch");
        ipl_n = 3'b111; strobes(3, "glitch");
        chk("glitch_out", {5'd0, ipl_out}, 8'd0);

        // Held level 4 is accepted.
        ipl_n = 3'b011; strobes(3, "lvl4");
        chk("lvl4_out", {5'd0, ipl_out}, 8'd4);
        chk("lvl4_pins", {6'd0, pi_ipl2, pi_ipl1}, 8'd2);

        // Freeze during a transaction, apply on release.
        txn_busy = 1'b1; ipl_n = 3'b101; strobes(5, "frozen");
        chk("frozen_out", {5'd0, ipl_out}, 8'd4);
        txn_busy = 1'b0; tick("unfreeze");
        chk("unfreeze_out", {5'd0, ipl_out}, 8'd2);

        // NMI entry despite freeze, held until status read.
        txn_busy = 1'b1; ipl_n = 3'b000; strobes(3, "nmi");
        chk("nmi_flag", {7'd0, nmi_latched}, 8'd1);
        ipl_n = 3'b111; strobes(3, "nmi_hold");
        chk("nmi_hold_out", {5'd0, ipl_out}, 8'd7);
        pulse_rd("nmi_ack");
        chk("nmi_ack_out", {4'd0, ipl_out, nmi_latched}, 8'd0);
        txn_busy = 1'b0;

        // Held 7 across an ack stays active at 7 without re-latching.
        ipl_n = 3'b000; strobes(3, "nmi2");
        pulse_rd("ack_held7");
        chk("held7", {4'd0, ipl_out, nmi_latched}, 8'he);
        pulse_rd("extra_rd"); tick("extra_rd"); pulse_rd("extra_rd");
        ipl_n = 3'b010; strobes(3, "lvl5");
        chk("lvl5_out", {5'd0, ipl_out}, 8'd5);
        ipl_n = 3'b000; strobes(3, "relatch");
        chk("relatch", {7'd0, nmi_latched}, 8'd1);

        // Asynchronous reset while latched mid-transaction.
        txn_busy = 1'b1;
        #2 s0rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst", {ipl_out, pi_ipl2, pi_ipl1, irq_pending, nmi_latched, ipl_changed}, 8'd0);
        ipl_n = 3'b111;
        tick("in_rst");
        s0rst = 1'b0; txn_busy = 1'b0;
        strobes(5, "post_rst");
        chk("post_rst_out", {5'd0, ipl_out}, 8'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) ipl_n = 3'($urandom_range(0, 7));
            sample_en = ($urandom_range(0, 1) == 1);
            txn_busy  = ($urandom_range(0, 3) == 0) ? ~txn_busy : txn_busy;
            status_rd = ($urandom_range(0, 9) == 0);
            tick("random");
        end
        status_rd = 1'b0; sample_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ipl_sync_filter.md
Name: ipl_sync_filter

Overview:
- Sits between the 68K interrupt priority inputs (M68K_IPL_n[2:0]) and the Pi-facing status and IPL GPIO outputs of the bus bridge CPLD.
- Synchronises and de-glitches the IPL level, then freezes reported changes while a Pi bus transaction is in flight.
- Latches a level-7 (NMI) rising edge until the Pi acknowledges it by reading the status register.
- Its outputs feed the status-register read word and PI_IPL1/PI_IPL2.

Parameters:
- STABLE_CYCLES, 2: number of consecutive sample strobes a new IPL level must hold before it is accepted; legal range 1..7.
- FREEZE_ON_TXN, 1: 1 holds ipl_out constant while txn_busy is high (except NMI entry); 0 disables freezing.

Ports:
- clk  in  1  c8m-domain clock; all logic is on its rising edge.
- s0rst  in  1  reset, asynchronous, active-high.
- sample_en  in  1  one-clk strobe (c8m rising qualifier); filter advances only when high.
- ipl_n  in  3  raw M68K_IPL_n, active-low, asynchronous.
- txn_busy  in  1  PI_TXN_IN_PROGRESS.
- status_rd  in  1  one-clk pulse, Pi read of REG_STATUS completed.
- ipl_out  out  3  reported priority level, active-high, 0..7.
- pi_ipl1  out  1  equals ipl_out[1].
- pi_ipl2  out  1  equals ipl_out[2].
- irq_pending  out  1  high when ipl_out != 0.
- nmi_latched  out  1  high while in state LATCH7.
- ipl_changed  out  1  one-clk pulse on the cycle after ipl_out changes value.

Behaviour:
- Reset (s0rst high, any time including mid-transaction):
  - sync flops = 3'b000 (inactive, i.e. ~ipl_n), stable level = 0, filter counter = 0, state IDLE.
  - All outputs 0; any latched NMI is discarded.
- Synchroniser: 2-flop on ~ipl_n, clocked every clk regardless of sample_en. Synchronised value is lvl_s.
- Filter, on sample_en only:
  - If lvl_s == candidate, counter increments, saturating at STABLE_CYCLES.
  - Otherwise candidate <= lvl_s and counter <= 1.
  - When counter reaches STABLE_CYCLES, stable <= candidate.
  - Latency from an ipl_n change to stable: 2 clk (sync) + STABLE_CYCLES strobes.
  - A glitch shorter than STABLE_CYCLES strobes never reaches stable.
- freeze = FREEZE_ON_TXN && txn_busy.
- State machine, registered, one transition per clk:
  - IDLE (ipl_out = 0):
    - stable == 7 -> LATCH7, ipl_out <= 7, regardless of freeze.
    - stable in 1..6 and !freeze -> ACTIVE, ipl_out <= stable.
    - Otherwise stay.
  - ACTIVE (ipl_out tracks stable):
    - stable == 7 and prev_stable != 7 -> LATCH7, ipl_out <= 7, regardless of freeze.
    - Else if !freeze and stable != ipl_out: stable == 0 -> IDLE, ipl_out <= 0; otherwise ipl_out <= stable and stay.
    - Frozen changes are applied on the first clk after txn_busy falls, using the stable value at that time.
  - LATCH7 (ipl_out = 7, nmi_latched = 1):
    - Leave only on status_rd. Target state is chosen by stable in the same cycle: 0 -> IDLE; 1..7 -> ACTIVE with ipl_out <= stable.
    - Ignores freeze on exit.
    - A held level 7 after ack stays ACTIVE at 7 and does not re-latch. A new NMI requires stable to drop below 7 and rise again.
- Simultaneous events:
  - status_rd in the same cycle as a stable change: the ack is processed first, then the new stable value selects the target state.
  - status_rd outside LATCH7 is ignored.
- prev_stable is a register updated every clk.
- ipl_changed is registered: (ipl_out_next != ipl_out) delayed by one clk.
- pi_ipl1, pi_ipl2 and irq_pending are combinational from ipl_out.

Test Plan:
- Reset, then hold ipl_n = 3'b111 for 20 strobes -> ipl_out = 0, irq_pending = 0, ipl_changed never pulses.
- STABLE_CYCLES = 2: drive ipl_n = 3'b011 (level 4) for 1 strobe, then 3'b111 -> ipl_out stays 0. Hold level 4 -> ipl_out = 4 after 2 clk + 2 strobes, pi_ipl2 = 1, pi_ipl1 = 0, one ipl_changed pulse.
- From ipl_out = 4, raise txn_busy, change to level 2 and wait 5 strobes -> ipl_out stays 4. Drop txn_busy -> ipl_out = 2 on the next clk.
- With txn_busy = 1, drive level 7 -> ipl_out = 7 and nmi_latched = 1 despite freeze. Drop to level 0 -> ipl_out stays 7. Pulse status_rd -> ipl_out = 0, state IDLE, nmi_latched = 0.
- Hold level 7, pulse status_rd -> ACTIVE with ipl_out = 7 and nmi_latched = 0. Further status_rd pulses cause no change. Drop to 5 then raise to 7 -> LATCH7 again.
- Assert s0rst asynchronously while in LATCH7 mid-transaction -> all outputs 0 immediately. After release with level 0, stays IDLE.
